// File: rtl/hamming_pkg.sv
// Shared constants and types for the (7,4) Hamming receive/correct/transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: codeword/data widths, deserializer state encoding, serial frame line levels.
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int IDX_W  = $clog2(CODE_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } deser_state_t;

    // Serial frame line levels
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/hamming_rx_deser_if.sv
// Serial input and codeword output bundle of the Hamming receive deserializer.
// Latency: n/a (wiring only).
// Backpressure: code_valid/code_ready handshake; the serial side has no backpressure.
// master = deserializer (consumes ser_*, parity_type, code_ready; drives code_*),
// slave  = line driver plus downstream corrector (the mirror image).
interface hamming_rx_deser_if;

    logic                          ser_in;
    logic                          ser_valid;
    logic                          parity_type;
    logic [hamming_pkg::CODE_W:1]  code_word;
    logic                          code_ptype;
    logic                          code_valid;
    logic                          code_ready;

    modport master (
        input  ser_in, ser_valid, parity_type, code_ready,
        output code_word, code_ptype, code_valid
    );

    modport slave (
        output ser_in, ser_valid, parity_type, code_ready,
        input  code_word, code_ptype, code_valid
    );

endinterface

// File: rtl/hamming_obuf.sv
// Single-entry valid/ready holding register for completed codewords, with sticky overflow.
// Latency: out_vld rises the cycle after in_vld; a consume and a load in the same cycle chain with no bubble.
// Backpressure: when full and not consumed, a new word is dropped and overflow is set.
// Ports: clk, rst_n; in_vld/in_word/in_ptype (completed word); out_vld/out_word/out_ptype/out_rdy; clr_ovf, overflow.
module hamming_obuf
    import hamming_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [CODE_W:1]   in_word,
    input  logic              in_ptype,
    output logic              out_vld,
    output logic [CODE_W:1]   out_word,
    output logic              out_ptype,
    input  logic              out_rdy,
    input  logic              clr_ovf,
    output logic              overflow
);

    logic consume;
    logic drop;

    assign consume = out_vld && out_rdy;
    // Full and not draining this cycle: the incoming word has nowhere to go.
    assign drop    = in_vld && out_vld && !out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_word  <= '0;
            out_ptype <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (in_vld && (!out_vld || consume)) begin
                out_vld   <= 1'b1;
                out_word  <= in_word;
                out_ptype <= in_ptype;
            end else if (consume) begin
                out_vld   <= 1'b0;
            end

            // A new drop outranks a clear in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hamming_rx_deser.sv
// Framed serial-to-parallel receiver: start bit, 7 code bits ([1] first), stop bit -> codeword.
// Latency: code_valid / frame_err appear the cycle after the edge that samples the stop bit.
// Backpressure: one-entry output register; a word completed while it is full is dropped and flags overflow.
// Ports: clk, rst_n; bus (hamming_rx_deser_if.master); frame_err pulse; overflow sticky; clr_ovf clear.
module hamming_rx_deser
    import hamming_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    hamming_rx_deser_if.master  bus,
    output logic                frame_err,
    output logic                overflow,
    input  logic                clr_ovf
);

    deser_state_t       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CODE_W:1]    shreg_q, shreg_d;
    logic               ptype_q, ptype_d;
    logic               word_done;
    logic               stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            shreg_q   <= '0;
            ptype_q   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            ptype_q   <= ptype_d;
            frame_err <= stop_bad;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        ptype_d   = ptype_q;
        word_done = 1'b0;
        stop_bad  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ser_valid && bus.ser_in == START_LVL) begin
                    state_d = DATA;
                    idx_d   = '0;
                    ptype_d = bus.parity_type;
                end
            end
            DATA: begin
                if (bus.ser_valid) begin
                    // Shifting in from the top leaves the first received bit
                    // in position [1] once all CODE_W bits have arrived.
                    shreg_d = {bus.ser_in, shreg_q[CODE_W:2]};
                    if (idx_q == IDX_W'(CODE_W - 1)) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bus.ser_valid) begin
                    // A bad stop bit returns to IDLE without being taken as a start bit.
                    state_d = IDLE;
                    if (bus.ser_in == STOP_LVL) begin
                        word_done = 1'b1;
                    end else begin
                        stop_bad  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    hamming_obuf u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (word_done),
        .in_word   (shreg_q),
        .in_ptype  (ptype_q),
        .out_vld   (bus.code_valid),
        .out_word  (bus.code_word),
        .out_ptype (bus.code_ptype),
        .out_rdy   (bus.code_ready),
        .clr_ovf   (clr_ovf),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_hamming_rx_deser.sv
// Self-checking bench for hamming_rx_deser: directed frames plus randomized framed traffic.
// Latency: n/a.
// Backpressure: code_ready driven directly or randomized; expected words kept in a one-slot queue model.
module tb_hamming_rx_deser;
    import hamming_pkg::*;

    typedef struct packed {
        logic [CODE_W:1] w;
        logic            p;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_err;
    logic overflow;
    logic clr_ovf;

    hamming_rx_deser_if bus_if();

    hamming_rx_deser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .frame_err (frame_err),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t mdl_q[$];
    bit   mdl_ovf = 1'b0;
    int   ferr_cnt = 0;
    int   hs_cnt = 0;
    int   n_push = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Observe at the falling edge; a handshake seen here happens at the next rising edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            check("valid", bus_if.code_valid, 32'(mdl_q.size() != 0));
            check("overflow", overflow, 32'(mdl_ovf));
            if (frame_err) ferr_cnt++;
            if (bus_if.code_valid && bus_if.code_ready && mdl_q.size() != 0) begin
                e = mdl_q.pop_front();
                check("word", bus_if.code_word, 32'(e.w));
                check("ptype", bus_if.code_ptype, 32'(e.p));
                hs_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Gap cycles (strobe low, junk on the line), then present one strobed bit without clocking it.
    task automatic drive_bit(input logic b, input int gap, input bit rand_rdy);
        repeat (gap) begin
            bus_if.ser_valid = 1'b0;
            bus_if.ser_in    = 1'($urandom);
            if (rand_rdy) bus_if.code_ready = 1'($urandom);
            step();
        end
        bus_if.ser_in    = b;
        bus_if.ser_valid = 1'b1;
        if (rand_rdy) bus_if.code_ready = 1'($urandom);
    endtask

    task automatic send_frame(input logic [CODE_W:1] w, input logic p, input logic stop,
                              input int maxgap, input bit rand_rdy, input bit pulse_rdy);
        int   sz;
        logic rdy;
        exp_t e;
        drive_bit(START_LVL, $urandom_range(maxgap, 0), rand_rdy);
        bus_if.parity_type = p;
        step();
        bus_if.parity_type = 1'($urandom);  // must be ignored until the next start bit
        for (int i = 1; i <= CODE_W; i++) begin
            drive_bit(w[i], $urandom_range(maxgap, 0), rand_rdy);
            step();
        end
        drive_bit(stop, $urandom_range(maxgap, 0), rand_rdy);
        if (pulse_rdy) bus_if.code_ready = 1'b1;
        sz  = mdl_q.size();
        rdy = bus_if.code_ready;
        step();
        if (stop) begin
            if (sz == 0 || rdy) begin
                e.w = w;
                e.p = p;
                mdl_q.push_back(e);
                n_push++;
            end else begin
                mdl_ovf = 1'b1;
            end
        end
        if (pulse_rdy) bus_if.code_ready = 1'b0;
        bus_if.ser_valid = 1'b0;
        bus_if.ser_in    = IDLE_LVL;
    endtask

    task automatic clear_ovf();
        clr_ovf = 1'b1;
        step();
        mdl_ovf = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic drain();
        int k;
        bus_if.code_ready = 1'b1;
        k = 0;
        while ((mdl_q.size() != 0 || bus_if.code_valid) && k < 40) begin
            step();
            k++;
        end
        step();
        check("drain", 32'(mdl_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word"}, bus_if.code_word, 32'd0);
        check({tag, "_ptype"}, bus_if.code_ptype, 32'd0);
        check({tag, "_valid"}, bus_if.code_valid, 32'd0);
        check({tag, "_ferr"}, frame_err, 32'd0);
        check({tag, "_ovf"}, overflow, 32'd0);
    endtask

    initial begin
        int   f0;
        int   h0;
        logic p;

        rst_n              = 1'b0;
        clr_ovf            = 1'b0;
        bus_if.ser_in      = IDLE_LVL;
        bus_if.ser_valid   = 1'b0;
        bus_if.parity_type = 1'b0;
        bus_if.code_ready  = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n  = 1'b1;
        step();
        mon_en = 1'b1;

        // Basic frame 0,1,0,1,0,1,0,1,1
        bus_if.code_ready = 1'b1;
        send_frame(7'b1010101, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        repeat (3) step();
        check("basic_hs", hs_cnt, 32'd1);

        // Bad stop bit, then a clean all-zero frame
        f0 = ferr_cnt;
        send_frame(7'b0110011, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        repeat (3) step();
        check("ferr_pulse", ferr_cnt - f0, 32'd1);
        check("ferr_no_word", hs_cnt, 32'd1);
        send_frame(7'b0000000, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        repeat (3) step();
        check("after_ferr_hs", hs_cnt, 32'd2);

        // Overflow: two words with the output stalled
        bus_if.code_ready = 1'b0;
        send_frame(7'b1111111, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_frame(7'b0110011, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        repeat (2) step();
        check("ovf_held_word", bus_if.code_word, 32'h7f);
        check("ovf_set", overflow, 32'd1);
        bus_if.code_ready = 1'b1;
        step();
        bus_if.code_ready = 1'b0;
        check("ovf_consumed", bus_if.code_valid, 32'd0);
        check("ovf_hs", hs_cnt, 32'd3);
        clear_ovf();
        check("ovf_cleared", overflow, 32'd0);

        // Completion in the same cycle the held word is consumed
        send_frame(7'b0101010, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_frame(7'b1100110, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        step();
        check("chain_word", bus_if.code_word, 32'h66);
        check("chain_valid", bus_if.code_valid, 32'd1);
        check("chain_ovf", overflow, 32'd0);
        drain();

        // Random codewords with strobe gaps, toggling parity, ready held high
        p = 1'b0;
        bus_if.code_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send_frame(7'($urandom), p, 1'b1, 3, 1'b0, 1'b0);
            p = ~p;
        end
        // Back-to-back frames, random backpressure (drops are predicted by the model)
        for (int i = 0; i < 20; i++) begin
            send_frame(7'($urandom), p, 1'b1, (i < 10) ? 0 : 2, 1'b1, 1'b0);
            p = ~p;
        end
        drain();
        clear_ovf();
        check("rand_all_seen", hs_cnt, 32'(n_push));

        // Reset mid-frame with a word held
        bus_if.code_ready = 1'b0;
        send_frame(7'b0011100, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        drive_bit(START_LVL, 0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive_bit(1'($urandom), 0, 1'b0);
            step();
        end
        rst_n = 1'b0;
        mdl_q.delete();
        mdl_ovf = 1'b0;
        bus_if.ser_valid = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) step();
        rst_n = 1'b1;
        step();
        h0 = hs_cnt;
        bus_if.code_ready = 1'b1;
        send_frame(7'b1001100, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        drain();
        check("post_rst_hs", hs_cnt - h0, 32'd1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_rx_deser.md
# hamming_rx_deser

Serial-to-parallel receive stage for the (7,4) Hamming path. It assembles framed serial bits (start bit, 7 code bits, stop bit) into a 7-bit codeword. It hands each codeword over a valid/ready handshake to the Hamming corrector, which sits directly downstream and consumes `code_word` and `code_ptype`. It also flags framing errors and overflow so link faults are not mistaken for correctable bit errors.

## Interface
- `CODE_W`, 7, codeword width; bits are indexed `[CODE_W:1]` to match the corrector.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ser_in`  in  1  serial line; idles high.
- `ser_valid`  in  1  bit strobe; `ser_in` is sampled only on cycles where `ser_valid`=1.
- `parity_type`  in  1  parity mode (0 = even, 1 = odd); latched at start bit.
- `code_word`  out  CODE_W  assembled codeword, `[1]` received first.
- `code_ptype`  out  1  parity mode latched for this word.
- `code_valid`  out  1  `code_word` holds an unconsumed word.
- `code_ready`  in  1  downstream accepts the word when `code_valid && code_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `overflow`  out  1  sticky: a completed word was dropped because the output was full.
- `clr_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- FSM states: IDLE, DATA, STOP.
  - IDLE: a strobed `ser_in`=0 is the start bit. Latch `parity_type`, clear bit index, go to DATA. A strobed 1 stays in IDLE.
  - DATA: each strobe shifts `ser_in` into shift bit `idx+1`, with `idx` running 0..CODE_W-1. After bit CODE_W, go to STOP.
  - STOP: next strobe. If it is 1, the word completes and the FSM returns to IDLE. If it is 0, pulse `frame_err`, discard the word, and return to IDLE; the 0 is not reinterpreted as a start bit.
- Output register: one entry holding `code_word`, `code_ptype` and `code_valid`.
  - On word completion with the register empty, or being consumed in the same cycle: load the register and assert `code_valid`.
  - On word completion with the register full and not consumed: drop the new word, set `overflow`, and keep the held word unchanged.
  - Consume (`code_valid && code_ready`) with no new word: clear `code_valid`.
- While `code_valid`=1 and `code_ready`=0, `code_word` and `code_ptype` are held stable.
- `overflow` stays set until `clr_ovf`. If `clr_ovf` coincides with a new overflow event, the set wins.
- Cycles with `ser_valid`=0 do not advance the FSM or the index; the strobe rate is arbitrary, down to back-to-back.

## Timing
- Reset values: `code_word`=0, `code_ptype`=0, `code_valid`=0, `frame_err`=0, `overflow`=0, FSM=IDLE, index=0.
- Reset mid-frame or with a word held: the partial frame is discarded, the held word is lost, and the block returns to IDLE. It resumes with the next start bit after reset deasserts.
- Latency: `code_valid` rises in the cycle after the clock edge that samples a good stop bit (registered output). `frame_err` pulses in that same cycle, for exactly one cycle.
- Minimum frame length is 9 strobes. Back-to-back frames are accepted: a start bit may arrive on the strobe immediately after the stop bit.
- Throughput is one word per 9 strobes when `code_ready` is held high. No bubble is inserted by the handshake.
- `code_valid` never drops without a handshake, except on reset.

## Structure
- Shared package `hamming_pkg`:
  - `CODE_W`=7 and `DATA_W`=4.
  - Deserializer state enum (IDLE/DATA/STOP).
  - Frame constants: start level 0, stop level 1, idle level 1.
  - The package is shared with the corrector and the transmit serializer.
- One sub-module is natural: `hamming_obuf`, the single-entry valid/ready holding register with overflow detect. The FSM and shift register stay in the top.

## Test plan
- Reset, then send frame 0,1,0,1,0,1,0,1,1 with `code_ready`=1 and `parity_type`=0. Required: `code_word`=7'b1010101 and `code_ptype`=0, `code_valid`=1 for one cycle.
- Send frame 0 + bits 1,1,0,0,1,1,0 + stop 0. Required: `frame_err` pulses once, `code_valid` stays 0. A following valid frame for 7'b0000000 is then received correctly.
- Set `code_ready`=0 and send two good frames, 7'b1111111 then 7'b0110011. Required: `code_word` holds 7'b1111111 and `overflow`=1. After `code_ready`=1 for one cycle, `code_valid`=0. After `clr_ovf`, `overflow`=0.
- Hold the output full, then complete a new word in the same cycle `code_ready`=1. Required: the new word loads, `code_valid` stays 1, and `overflow` stays 0.
- Interleave `ser_valid`=0 gaps of 0–3 cycles within frames of random codewords, with `parity_type` toggling between frames. Required: every word and `code_ptype` match the sent frames, in order.
- Assert `rst_n`=0 after 4 data bits of a frame. Required: all outputs are 0 immediately. A full frame for 7'b1001100 sent after release is received correctly.
